// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALUop codes,
// main-FSM state encodings and the packed control word driven by the main FSM.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH  = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADDR = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC    = 4'd6,
        RWB     = 4'd7,
        BRANCH  = 4'd8,
        JUMP    = 4'd9,
        ADDI_EX = 4'd10,
        ADDI_WB = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        logic legal;
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
            default:                                               legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multicycle MIPS datapath: sequences every datapath
// enable/select from the registered state, stalling on memory via mem_ready.
module multicycle_main_control
    import mips_ctrl_pkg::*;
#(
    parameter int OPW = 6,
    parameter int STW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] opcode,
    input  logic           mem_ready,
    output logic           PCWrite,
    output logic           PCWriteCond,
    output logic           BranchNE,
    output logic           IorD,
    output logic           MemRead,
    output logic           MemWrite,
    output logic           IRWrite,
    output logic           MemtoReg,
    output logic           RegDst,
    output logic           RegWrite,
    output logic           ALUSrcA,
    output logic [1:0]     ALUSrcB,
    output logic [1:0]     ALUop,
    output logic [1:0]     PCSource,
    output logic           illegal_op,
    output logic [STW-1:0] state_dbg
);

    state_t state_r;
    ctl_t   ctl_s;
    ctl_t   ctl_out_s;

    // State register and next-state sequencing; unused encodings fall back to FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= FETCH;
        end else begin
            case (state_r)
                FETCH:   state_r <= mem_ready ? DECODE : FETCH;
                DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW:   state_r <= MEMADDR;
                        OP_RTYPE:       state_r <= EXEC;
                        OP_BEQ, OP_BNE: state_r <= BRANCH;
                        OP_J:           state_r <= JUMP;
                        OP_ADDI:        state_r <= ADDI_EX;
                        default:        state_r <= FETCH;
                    endcase
                end
                MEMADDR: state_r <= (opcode == OP_LW) ? MEMRD : MEMWR;
                MEMRD:   state_r <= mem_ready ? MEMWB : MEMRD;
                MEMWR:   state_r <= mem_ready ? FETCH : MEMWR;
                EXEC:    state_r <= RWB;
                ADDI_EX: state_r <= ADDI_WB;
                MEMWB, RWB, BRANCH, JUMP, ADDI_WB: state_r <= FETCH;
                default: state_r <= FETCH;
            endcase
        end
    end

    // Moore decode of the current state into the control word.
    always_comb begin
        ctl_s = '0;
        case (state_r)
            FETCH: begin
                ctl_s.mem_read  = 1'b1;
                ctl_s.alu_src_b = SRCB_FOUR;
                ctl_s.alu_op    = ALUOP_ADD;
                ctl_s.pc_source = PCSRC_ALU;
                ctl_s.ir_write  = mem_ready;
                ctl_s.pc_write  = mem_ready;
            end
            DECODE: begin
                ctl_s.alu_src_b  = SRCB_IMMSH;
                ctl_s.alu_op     = ALUOP_ADD;
                ctl_s.illegal_op = ~is_legal_op(opcode);
            end
            MEMADDR, ADDI_EX: begin
                ctl_s.alu_src_a = 1'b1;
                ctl_s.alu_src_b = SRCB_IMM;
                ctl_s.alu_op    = ALUOP_ADD;
            end
            MEMRD: begin
                ctl_s.mem_read = 1'b1;
                ctl_s.ior_d    = 1'b1;
            end
            MEMWB: begin
                ctl_s.reg_write  = 1'b1;
                ctl_s.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                ctl_s.mem_write = 1'b1;
                ctl_s.ior_d     = 1'b1;
            end
            EXEC: begin
                ctl_s.alu_src_a = 1'b1;
                ctl_s.alu_src_b = SRCB_B;
                ctl_s.alu_op    = ALUOP_FUNCT;
            end
            RWB: begin
                ctl_s.reg_write = 1'b1;
                ctl_s.reg_dst   = 1'b1;
            end
            BRANCH: begin
                ctl_s.alu_src_a     = 1'b1;
                ctl_s.alu_src_b     = SRCB_B;
                ctl_s.alu_op        = ALUOP_SUB;
                ctl_s.pc_write_cond = 1'b1;
                ctl_s.pc_source     = PCSRC_ALUOUT;
                ctl_s.branch_ne     = opcode[0];
            end
            JUMP: begin
                ctl_s.pc_write  = 1'b1;
                ctl_s.pc_source = PCSRC_JUMP;
            end
            ADDI_WB: begin
                ctl_s.reg_write = 1'b1;
            end
            default: begin
                ctl_s = '0;
            end
        endcase
    end

    // Reset holds every control line low, even though the state already reads FETCH.
    assign ctl_out_s = rst_n ? ctl_s : ctl_t'({$bits(ctl_t){1'b0}});

    assign PCWrite     = ctl_out_s.pc_write;
    assign PCWriteCond = ctl_out_s.pc_write_cond;
    assign BranchNE    = ctl_out_s.branch_ne;
    assign IorD        = ctl_out_s.ior_d;
    assign MemRead     = ctl_out_s.mem_read;
    assign MemWrite    = ctl_out_s.mem_write;
    assign IRWrite     = ctl_out_s.ir_write;
    assign MemtoReg    = ctl_out_s.mem_to_reg;
    assign RegDst      = ctl_out_s.reg_dst;
    assign RegWrite    = ctl_out_s.reg_write;
    assign ALUSrcA     = ctl_out_s.alu_src_a;
    assign ALUSrcB     = ctl_out_s.alu_src_b;
    assign ALUop       = ctl_out_s.alu_op;
    assign PCSource    = ctl_out_s.pc_source;
    assign illegal_op  = ctl_out_s.illegal_op;
    assign state_dbg   = STW'(state_r);

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control: walks each instruction class
// cycle by cycle and compares state_dbg and the whole control word to constants.
module tb_multicycle_main_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
    logic [1:0] ALUSrcB, ALUop, PCSource;
    logic [3:0] state_dbg;

    int checks = 0;
    int errors = 0;

    // Field order: PCWrite PCWriteCond BranchNE IorD MemRead MemWrite IRWrite
    //              MemtoReg RegDst RegWrite ALUSrcA ALUSrcB ALUop PCSource illegal_op
    localparam logic [17:0] C_ZERO     = 18'b0_0_0_0_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [17:0] C_FETCH_R  = 18'b1_0_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [17:0] C_FETCH_W  = 18'b0_0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [17:0] C_DECODE   = 18'b0_0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [17:0] C_DEC_ILL  = 18'b0_0_0_0_0_0_0_0_0_0_0_11_00_00_1;
    localparam logic [17:0] C_MEMADDR  = 18'b0_0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [17:0] C_MEMRD    = 18'b0_0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [17:0] C_MEMWB    = 18'b0_0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [17:0] C_MEMWR    = 18'b0_0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [17:0] C_EXEC     = 18'b0_0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [17:0] C_RWB      = 18'b0_0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [17:0] C_BNE      = 18'b0_1_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [17:0] C_BEQ      = 18'b0_1_0_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [17:0] C_JUMP     = 18'b1_0_0_0_0_0_0_0_0_0_0_00_00_10_0;
    localparam logic [17:0] C_ADDI_EX  = 18'b0_0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [17:0] C_ADDI_WB  = 18'b0_0_0_0_0_0_0_0_0_1_0_00_00_00_0;

    wire [17:0] ctl = {PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite,
                       MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource,
                       illegal_op};

    multicycle_main_control #(.OPW(6), .STW(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNE(BranchNE),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUop(ALUop), .PCSource(PCSource),
        .illegal_op(illegal_op), .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Check the current cycle (inputs already applied), then advance one clock.
    task automatic cyc(input string tag, input logic [3:0] st, input logic [17:0] c);
        #1;
        check({tag, " state"}, {28'd0, state_dbg}, {28'd0, st});
        check({tag, " ctl"}, {14'd0, ctl}, {14'd0, c});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = 6'b000000;
        mem_ready = 1'b1;
        #2;
        check("por state", {28'd0, state_dbg}, 32'd0);
        check("por ctl", {14'd0, ctl}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Dangling fetch after reset: let it reach FETCH of a fresh lw.
        opcode = 6'b100011;
        cyc("lw0", 4'd1, C_DECODE);
        cyc("lw1", 4'd2, C_MEMADDR);
        cyc("lw2", 4'd3, C_MEMRD);
        cyc("lw3", 4'd4, C_MEMWB);
        cyc("lw_f", 4'd0, C_FETCH_R);
        cyc("lw_d", 4'd1, C_DECODE);
        cyc("lw_a", 4'd2, C_MEMADDR);
        cyc("lw_r", 4'd3, C_MEMRD);
        cyc("lw_wb", 4'd4, C_MEMWB);

        opcode = 6'b000000;
        cyc("r_f", 4'd0, C_FETCH_R);
        cyc("r_d", 4'd1, C_DECODE);
        cyc("r_ex", 4'd6, C_EXEC);
        cyc("r_wb", 4'd7, C_RWB);

        opcode = 6'b000101;
        cyc("bne_f", 4'd0, C_FETCH_R);
        cyc("bne_d", 4'd1, C_DECODE);
        cyc("bne_b", 4'd8, C_BNE);
        opcode = 6'b000100;
        cyc("beq_f", 4'd0, C_FETCH_R);
        cyc("beq_d", 4'd1, C_DECODE);
        cyc("beq_b", 4'd8, C_BEQ);

        opcode = 6'b000010;
        cyc("j_f", 4'd0, C_FETCH_R);
        cyc("j_d", 4'd1, C_DECODE);
        cyc("j_j", 4'd9, C_JUMP);

        opcode = 6'b001000;
        cyc("addi_f", 4'd0, C_FETCH_R);
        cyc("addi_d", 4'd1, C_DECODE);
        cyc("addi_ex", 4'd10, C_ADDI_EX);
        cyc("addi_wb", 4'd11, C_ADDI_WB);

        // sw with two FETCH stalls and three MEMWR stalls: 9 cycles in total.
        opcode    = 6'b101011;
        mem_ready = 1'b0;
        cyc("sw_f0", 4'd0, C_FETCH_W);
        cyc("sw_f1", 4'd0, C_FETCH_W);
        mem_ready = 1'b1;
        cyc("sw_f2", 4'd0, C_FETCH_R);
        cyc("sw_d", 4'd1, C_DECODE);
        cyc("sw_a", 4'd2, C_MEMADDR);
        mem_ready = 1'b0;
        cyc("sw_w0", 4'd5, C_MEMWR);
        cyc("sw_w1", 4'd5, C_MEMWR);
        cyc("sw_w2", 4'd5, C_MEMWR);
        mem_ready = 1'b1;
        cyc("sw_w3", 4'd5, C_MEMWR);

        // lw with a single MEMRD stall.
        opcode = 6'b100011;
        cyc("lws_f", 4'd0, C_FETCH_R);
        cyc("lws_d", 4'd1, C_DECODE);
        cyc("lws_a", 4'd2, C_MEMADDR);
        mem_ready = 1'b0;
        cyc("lws_r0", 4'd3, C_MEMRD);
        mem_ready = 1'b1;
        cyc("lws_r1", 4'd3, C_MEMRD);
        cyc("lws_wb", 4'd4, C_MEMWB);

        opcode = 6'b111111;
        cyc("ill_f", 4'd0, C_FETCH_R);
        cyc("ill_d", 4'd1, C_DEC_ILL);

        // Reset asserted in EXEC: outputs forced low, state FETCH, then clean restart.
        opcode = 6'b000000;
        cyc("rst_f", 4'd0, C_FETCH_R);
        cyc("rst_d", 4'd1, C_DECODE);
        #1;
        check("pre_rst exec", {28'd0, state_dbg}, 32'd6);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc("in_rst", 4'd0, C_ZERO);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel state", {28'd0, state_dbg}, 32'd0);
        check("rel ctl", {14'd0, ctl}, {14'd0, C_FETCH_R});
        @(posedge clk);
        #1;
        cyc("rel_d", 4'd1, C_DECODE);
        cyc("rel_ex", 4'd6, C_EXEC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
Main control FSM for the multicycle MIPS datapath. It decodes the 6-bit opcode held in the instruction register and sequences every datapath enable and mux select. It is the producer side of the ALUop interface: it drives the 2-bit ALUop that the ALU control decoder combines with funct. Memory accesses use a ready handshake so slow memory can stall the FSM.

Parameters:
OPW, 6, opcode width
STW, 4, state register width (exposed on debug port)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
opcode  in  6  IR[31:26], valid from DECODE onward
mem_ready  in  1  memory completed the current access this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if branch condition true
BranchNE  out  1  1 = condition is ALU zero==0 (bne), 0 = zero==1 (beq)
IorD  out  1  memory address: 0 = PC, 1 = ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  load instruction register
MemtoReg  out  1  register write data: 0 = ALUOut, 1 = MDR
RegDst  out  1  destination register: 0 = rt, 1 = rd
RegWrite  out  1  register file write
ALUSrcA  out  1  0 = PC, 1 = A
ALUSrcB  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
ALUop  out  2  00 = add, 01 = subtract, 10 = use funct
PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
illegal_op  out  1  one-cycle pulse on unknown opcode
state_dbg  out  STW  current state encoding

Behaviour:
- Moore FSM; every output is a pure function of the state (and mem_ready for PCWrite in FETCH). Outputs are registered-state decodes with no extra latency.
- Reset: rst_n low forces state to FETCH asynchronously. While rst_n is low, all outputs are forced to 0 and state_dbg reads FETCH.
- Reset asserted mid-instruction aborts it with no partial write. The first active edge after release performs FETCH.
- States and encodings:
  - FETCH=0: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=00. IRWrite and PCWrite equal mem_ready. Stay while mem_ready=0, else go to DECODE.
  - DECODE=1: ALUSrcA=0, ALUSrcB=11, ALUop=00 (precompute branch target). Transitions by opcode:
    - 100011 (lw) or 101011 (sw): MEMADDR
    - 000000 (R-type): EXEC
    - 000100 (beq) or 000101 (bne): BRANCH
    - 000010 (j): JUMP
    - 001000 (addi): ADDI_EX
    - any other opcode: illegal_op=1 for this cycle, then FETCH
  - MEMADDR=2: ALUSrcA=1, ALUSrcB=10, ALUop=00. lw goes to MEMRD, sw goes to MEMWR.
  - MEMRD=3: MemRead=1, IorD=1. Hold until mem_ready, then MEMWB.
  - MEMWB=4: RegWrite=1, MemtoReg=1, RegDst=0. Then FETCH.
  - MEMWR=5: MemWrite=1, IorD=1. Hold until mem_ready, then FETCH.
  - EXEC=6: ALUSrcA=1, ALUSrcB=00, ALUop=10. Then RWB.
  - RWB=7: RegWrite=1, RegDst=1, MemtoReg=0. Then FETCH.
  - BRANCH=8: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=01, BranchNE=opcode[0]. Then FETCH.
  - JUMP=9: PCWrite=1, PCSource=10. Then FETCH.
  - ADDI_EX=10: ALUSrcA=1, ALUSrcB=10, ALUop=00. Then ADDI_WB.
  - ADDI_WB=11: RegWrite=1, RegDst=0, MemtoReg=0. Then FETCH.
  - Encodings 12-15 are unreachable; if entered, go to FETCH with all outputs 0.
- Outputs not listed for a state are 0 (ALUop 00, selects 00).
- MemRead and MemWrite are never both high. RegWrite is never high in the same cycle as MemWrite.
- Opcode is sampled in DECODE and again in MEMADDR and BRANCH. IR is stable because IRWrite is only high in FETCH.
- Cycle counts with mem_ready always high:
  - lw: 5
  - sw: 4
  - R-type: 4
  - addi: 4
  - beq/bne: 3
  - j: 3
  - illegal: 2
- Each wait cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI
  - ALUop constants: ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10
  - state encodings 0-11
- The ALU control decoder consumes the same ALUop constants.
- Single module: next-state logic plus an output decode block; no sub-module is warranted.

Test Plan:
- Reset: rst_n low for 3 cycles mid-EXEC -> all outputs 0 while low. State is FETCH, and the first cycle after release has MemRead=1, IRWrite=1, PCWrite=1.
- lw (opcode 100011), mem_ready=1 -> state sequence 0,1,2,3,4,0. ALUop=00 in DECODE and MEMADDR. RegWrite=1 and MemtoReg=1 only in cycle 5.
- R-type (opcode 000000) -> states 0,1,6,7. ALUop=10 only in EXEC. RegWrite=1 and RegDst=1 in RWB.
- bne (opcode 000101) -> BRANCH with ALUop=01, PCWriteCond=1, BranchNE=1, PCSource=01. Repeat with beq (000100) -> BranchNE=0.
- sw with mem_ready low for 2 cycles in FETCH and 3 in MEMWR -> FETCH held 3 cycles with IRWrite=0 until ready. MemWrite held 4 cycles. Total 9 cycles. RegWrite never asserted.
- Opcode 111111 -> illegal_op pulses in DECODE only, next state FETCH, no RegWrite, MemWrite or PCWrite asserted in DECODE.
